debounce_scheduler: RTL
=======================

# debounce_scheduler

Time-multiplexes one debounce interval counter across N noisy inputs, such as push-buttons and switches on the board I/O. It replaces N copies of a debouncer and its 20 ms timer. Each input is synchronized, and any input whose synchronized level differs from its debounced level requests the shared counter. A round-robin arbiter grants the counter to one requester at a time. Once the new level has held for the full interval, the block commits it and emits a one-cycle edge pulse. It sits between the raw pin inputs and the user-interface FSMs.

## Interface
- N, 4: number of noisy inputs, 1..16
- FINAL_VALUE, 1_999_999: terminal count of the shared counter; interval = FINAL_VALUE+1 cycles (20 ms at 100 MHz)
- CW, $clog2(FINAL_VALUE+1): counter width, derived
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- noisy  in  N  raw asynchronous inputs
- debounced  out  N  committed stable levels
- rise  out  N  one-cycle pulse when debounced[i] commits 0→1
- fall  out  N  one-cycle pulse when debounced[i] commits 1→0
- busy  out  1  high when state ≠ IDLE
- grant_idx  out  $clog2(N) (min 1)  index currently owning the counter; holds last value when idle

## Operation
- Per-input 2-flop synchronizer: s1 samples noisy, s2 samples s1. pending[i] = s2[i] ^ debounced[i].
- FSM states are IDLE, COUNT, and DONE.
- IDLE:
  - If pending is nonzero, grant g = the first set bit of pending, searching upward from ptr with wrap; load grant_idx=g, clear cnt, go to COUNT.
  - Otherwise stay in IDLE.
- COUNT, evaluated in this priority order:
  - If s2[g]==debounced[g] (input bounced back): abort, ptr=g+1 mod N, go to IDLE. debounced is unchanged and no pulse is emitted.
  - Else if cnt==FINAL_VALUE: toggle debounced[g]; set rise[g] if the new level is 1, otherwise fall[g]; ptr=g+1 mod N; go to DONE.
  - Else cnt=cnt+1.
- DONE lasts one cycle; the pulse registers are high during it. Always go to IDLE.
- Only the granted index is ever examined or committed. Other inputs keep pending and wait; their input changes while waiting are tracked by the synchronizer only.
- Round robin: ptr resets to 0 and always advances past the last granted index, whether that grant committed or aborted. A continuously bouncing input therefore cannot starve others.
- cnt never exceeds FINAL_VALUE and never wraps; it is compared with ==, not >=.
- N=1: ptr and grant_idx stay 0, and the behaviour equals a single debouncer.

## Timing
- Reset (rst low, asynchronous): s1, s2, debounced, rise, fall, cnt, ptr, and grant_idx all go to 0; busy=0; state=IDLE. Release is synchronous to the next clk edge.
- Reset mid-COUNT or mid-DONE: state returns to IDLE immediately, any pulse is dropped, and debounced returns to 0.
- Idle block; noisy[i] changes before edge 0 and stays stable:
  - s2 changes at edge 1.
  - Grant occurs at edge 2.
  - debounced[i] changes at edge FINAL_VALUE+3.
  - rise/fall is high for exactly the cycle after that edge.
  - Block is back in IDLE at edge FINAL_VALUE+4.
- Worst-case commit latency for an input waiting behind k other full intervals = k·(FINAL_VALUE+3) + FINAL_VALUE+3 cycles.
- Abort: detected in the first COUNT cycle where s2[g] matches debounced[g]; IDLE follows at the next edge. The next grant is issued one edge after that.
- Simultaneous requests in the same IDLE cycle: the lowest index at or after ptr wins.
- Outputs are all registered; there is no combinational path from noisy to any output.

## Structure
- Package debounce_pkg holds:
  - the state enum (IDLE, COUNT, DONE)
  - DEFAULT_FINAL_VALUE = 1_999_999
  - localparam function for index width, max(1, $clog2(N))
- Sub-module rr_arbiter, parameterized by N: inputs req[N] and ptr; outputs gnt_idx and any_req; purely combinational priority rotate. The FSM, counter, synchronizers, and debounced registers are in the top level.
- Existing timer_parameter is not reused; the counter needs the abort clear and the terminal compare in the same always block.

## Test plan
- N=4, FINAL_VALUE=7: after reset, all outputs are 0 and busy=0. Hold noisy=4'b0000 for 50 cycles → no pulses, state IDLE.
- Clean press on noisy[2] before edge 0 → debounced[2]=1 at edge 10, rise[2] high for one cycle, grant_idx=2, busy low at edge 11.
- noisy[1] bounces 1,0 with 3-cycle pulses, then stays 1 → aborts leave debounced[1]=0 with no pulses; the final stable level commits exactly FINAL_VALUE+3 edges after the last transition.
- noisy[0] and noisy[3] rise in the same cycle with ptr=0 → 0 commits first, 3 commits FINAL_VALUE+3 cycles later. Repeat the release with ptr=1 → 3 is served before 0.
- noisy[1] toggles every 4 cycles forever while noisy[2] rises → noisy[2] commits within 2·(FINAL_VALUE+3) cycles (no starvation).
- Assert rst low at COUNT cnt=4 → outputs clear asynchronously, no pulse. After release, the still-high input re-arbitrates and commits after a full interval.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the time-multiplexed debounce scheduler.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_FINAL_VALUE = 1_999_999;

  // Index width that never collapses to zero bits when N == 1.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_scheduler_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, with wrap.
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [idx_w(N)-1:0]   gnt_idx,
  output logic                  any_req
);
  localparam int IW = idx_w(N);

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int off);
    int j;
    j = int'(p) + off;
    if (j >= N) j = j - N;
    return IW'(j);
  endfunction

  assign any_req = |req;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[rot(ptr, i)]) gnt_idx = rot(ptr, i);
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// N-input debouncer sharing one interval counter under round-robin arbitration.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N           = 4,
  parameter int FINAL_VALUE = DEFAULT_FINAL_VALUE,
  parameter int CW          = (FINAL_VALUE < 1) ? 1 : $clog2(FINAL_VALUE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        noisy,
  output logic [N-1:0]        debounced,
  output logic [N-1:0]        rise,
  output logic [N-1:0]        fall,
  output logic                busy,
  output logic [idx_w(N)-1:0] grant_idx
);
  localparam int IW = idx_w(N);
  localparam logic [CW-1:0] TERM = CW'(FINAL_VALUE);

  state_t          state_q, state_d;
  logic [N-1:0]    s1_q, s2_q;
  logic [N-1:0]    deb_q, deb_d;
  logic [N-1:0]    rise_q, rise_d;
  logic [N-1:0]    fall_q, fall_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;

  logic [N-1:0]    pending;
  logic [IW-1:0]   arb_idx;
  logic            any_req;
  logic [IW-1:0]   ptr_nxt;

  assign pending = s2_q ^ deb_q;
  assign ptr_nxt = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;

  rr_arbiter #(.N(N)) u_arb (
    .req     (pending),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gidx_d  = arb_idx;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A bounce back to the committed level forfeits the slot to the next index.
        if (s2_q[gidx_q] == deb_q[gidx_q]) begin
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end else if (cnt_q == TERM) begin
          deb_d[gidx_q] = s2_q[gidx_q];
          if (s2_q[gidx_q]) rise_d[gidx_q] = 1'b1;
          else              fall_d[gidx_q] = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= noisy;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

  assign debounced = deb_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = (state_q != IDLE);
  assign grant_idx = gidx_q;

endmodule
